// File: rtl/host_if_pkg.sv
// Shared command codes, FSM states and defaults for the host stream deframer.
package host_if_pkg;

  localparam logic [7:0] ID_BYTE_DEFAULT = 8'hCD;

  localparam logic [3:0] CMD_PING  = 4'd0;
  localparam logic [3:0] CMD_WRITE = 4'd1;
  localparam logic [3:0] CMD_READ  = 4'd2;
  localparam logic [3:0] CMD_RESET = 4'd3;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StDecode,
    StAddress,
    StData,
    StNotify
  } state_e;

endpackage

// File: rtl/host_word_assembler.sv
// Big-endian byte-to-word assembler: word/word_done present the completed word
// combinationally in the cycle its last byte is accepted.
module host_word_assembler #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  input  logic [7:0]          data_byte,
  output logic [8*NBYTES-1:0] word,
  output logic                word_done
);

  logic [8*NBYTES-1:0] shift_q;
  logic [3:0]          cnt_q;
  logic [8*NBYTES+7:0] shift_cat;

  // Concatenate then truncate so NBYTES == 1 needs no zero-width slice.
  assign shift_cat = {shift_q, data_byte};
  assign word      = shift_cat[8*NBYTES-1:0];
  assign word_done = en && (cnt_q == 4'(NBYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (en) begin
      shift_q <= word;
      cnt_q   <= word_done ? 4'd0 : cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/host_stream_deframer.sv
// Parses framed host byte streams (ID, header, address, data) into
// master transactions with timeout and sof-abort handling.
module host_stream_deframer
  import host_if_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter logic [7:0]  ID_BYTE    = ID_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_byte,
  input  logic                    in_byte_valid,
  output logic                    in_byte_ready,
  input  logic                    sof,
  input  logic                    master_ready,
  output logic                    ih_ready,
  output logic                    ih_reset,
  output logic [31:0]             in_command,
  output logic [27:0]             in_data_count,
  output logic [31:0]             in_address,
  output logic [8*DATA_BYTES-1:0] in_data,
  output logic                    timeout_err,
  output logic                    bad_cmd_err
);

  localparam int unsigned DW  = 8 * DATA_BYTES;
  localparam logic [31:0] TMO = 32'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [23:0] remaining_q;
  logic        gather, accept, frame_byte, restart, expire, asm_clear;
  logic        hdr_en, hdr_done, dat_en, dat_done;
  logic [31:0] hdr_word;
  logic [DW-1:0] dat_word;
  logic        load_hdr, load_addr, load_rem, load_data;
  logic        ih_ready_d, ih_reset_d, timeout_err_d, bad_cmd_err_d;
  logic [3:0]  cmd;

  assign gather = (state_q == StHeader) || (state_q == StAddress) || (state_q == StData);
  // Gated by rst so every output reads 0 while reset is asserted.
  assign in_byte_ready = ~rst & (gather | (state_q == StIdle));
  assign accept        = in_byte_valid & in_byte_ready;
  assign restart       = accept & sof & gather;
  assign frame_byte    = accept & ~sof & gather;
  // An accepted byte always reloads, so a sof byte wins over expiry.
  assign expire        = (TMO != 32'd0) && gather && !accept && (tmr_q == 32'd0);
  assign asm_clear     = restart | expire;
  assign hdr_en        = frame_byte & ((state_q == StHeader) || (state_q == StAddress));
  assign dat_en        = frame_byte & (state_q == StData);
  assign cmd           = in_command[3:0];

  host_word_assembler #(
    .NBYTES(4)
  ) u_hdr_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (asm_clear),
    .en       (hdr_en),
    .data_byte(in_byte),
    .word     (hdr_word),
    .word_done(hdr_done)
  );

  host_word_assembler #(
    .NBYTES(DATA_BYTES)
  ) u_dat_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (asm_clear),
    .en       (dat_en),
    .data_byte(in_byte),
    .word     (dat_word),
    .word_done(dat_done)
  );

  always_comb begin
    tmr_d = tmr_q;
    if (accept) begin
      tmr_d = TMO;
    end else if (gather && (tmr_q != 32'd0)) begin
      tmr_d = tmr_q - 32'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    load_hdr      = 1'b0;
    load_addr     = 1'b0;
    load_rem      = 1'b0;
    load_data     = 1'b0;
    ih_ready_d    = 1'b0;
    ih_reset_d    = 1'b0;
    timeout_err_d = 1'b0;
    bad_cmd_err_d = 1'b0;
    if (restart) begin
      state_d = (in_byte == ID_BYTE) ? StHeader : StIdle;
    end else if (expire) begin
      state_d       = StIdle;
      timeout_err_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && sof && (in_byte == ID_BYTE)) state_d = StHeader;
        end
        StHeader: begin
          if (hdr_done) begin
            load_hdr = 1'b1;
            state_d  = StDecode;
          end
        end
        StDecode: begin
          state_d = StIdle;
          unique case (cmd)
            CMD_PING:  state_d = StNotify;
            CMD_RESET: ih_reset_d = 1'b1;
            CMD_READ:  state_d = StAddress;
            CMD_WRITE: begin
              if (in_data_count[23:0] == 24'd0) bad_cmd_err_d = 1'b1;
              else                              state_d = StAddress;
            end
            default:   bad_cmd_err_d = 1'b1;
          endcase
        end
        StAddress: begin
          if (hdr_done) begin
            load_addr = 1'b1;
            if (cmd == CMD_WRITE) begin
              load_rem = 1'b1;
              state_d  = StData;
            end else begin
              state_d = StNotify;
            end
          end
        end
        StData: begin
          if (dat_done) begin
            load_data = 1'b1;
            state_d   = StNotify;
          end
        end
        StNotify: begin
          if (master_ready) begin
            ih_ready_d = 1'b1;
            state_d = ((cmd == CMD_WRITE) && (remaining_q != 24'd0)) ? StData : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      tmr_q         <= TMO;
      remaining_q   <= '0;
      in_command    <= '0;
      in_data_count <= '0;
      in_address    <= '0;
      in_data       <= '0;
      ih_ready      <= 1'b0;
      ih_reset      <= 1'b0;
      timeout_err   <= 1'b0;
      bad_cmd_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      ih_ready    <= ih_ready_d;
      ih_reset    <= ih_reset_d;
      timeout_err <= timeout_err_d;
      bad_cmd_err <= bad_cmd_err_d;
      if (load_hdr) begin
        in_command    <= {12'h0, hdr_word[31:28], 12'h0, hdr_word[27:24]};
        in_data_count <= {4'h0, hdr_word[23:0]};
      end
      if (load_addr) in_address <= hdr_word;
      if (load_rem) remaining_q <= in_data_count[23:0];
      if (load_data) begin
        in_data <= dat_word;
        if (remaining_q != 24'd0) remaining_q <= remaining_q - 24'd1;
      end
    end
  end

endmodule

// File: tb/tb_host_stream_deframer.sv
// Directed and randomized checks of host_stream_deframer against a byte-position model.
module tb_host_stream_deframer;

  localparam int unsigned DB  = 4;
  localparam int unsigned DW  = 8 * DB;
  localparam int unsigned TMO = 16;
  localparam logic [7:0]  ID  = 8'hCD;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_byte;
  logic          in_byte_valid, in_byte_ready, sof, master_ready;
  logic          ih_ready, ih_reset, timeout_err, bad_cmd_err;
  logic [31:0]   in_command, in_address;
  logic [27:0]   in_data_count;
  logic [DW-1:0] in_data;

  host_stream_deframer #(
    .DATA_BYTES(DB),
    .ID_BYTE   (ID),
    .TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_byte      (in_byte),
    .in_byte_valid(in_byte_valid),
    .in_byte_ready(in_byte_ready),
    .sof          (sof),
    .master_ready (master_ready),
    .ih_ready     (ih_ready),
    .ih_reset     (ih_reset),
    .in_command   (in_command),
    .in_data_count(in_data_count),
    .in_address   (in_address),
    .in_data      (in_data),
    .timeout_err  (timeout_err),
    .bad_cmd_err  (bad_cmd_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position of accepted body bytes since the ID byte decides word boundaries.
  bit          m_frame;
  int          m_pos, m_stall, m_idle, m_words;
  logic [63:0] m_acc;
  logic [3:0]  m_cmd;
  logic [23:0] m_count;
  logic [31:0] e_command, e_address;
  logic [27:0] e_count;
  logic [DW-1:0] e_data;
  bit          e_ih_ready, e_ih_reset, e_tmo, e_bad;

  task automatic m_reset();
    m_frame = 0; m_pos = 0; m_stall = 0; m_idle = 0; m_words = 0; m_acc = '0;
    m_cmd = '0; m_count = '0; e_command = '0; e_address = '0; e_count = '0; e_data = '0;
    e_ih_ready = 0; e_ih_reset = 0; e_tmo = 0; e_bad = 0;
  endtask

  task automatic m_start();
    m_frame = 1; m_pos = 0; m_stall = 0; m_idle = 0; m_words = 0; m_acc = '0;
  endtask

  function automatic bit m_ready();
    return m_frame ? (m_stall == 0) : 1'b1;
  endfunction

  // m_stall: 0 = taking bytes, 1 = header decode cycle, 2 = waiting for master.
  task automatic m_update(input bit acc, input logic [7:0] b, input bit s, input bit mr);
    e_ih_ready = 0; e_ih_reset = 0; e_tmo = 0; e_bad = 0;
    if (!m_frame) begin
      if (acc && s && b == ID) m_start();
    end else if (m_stall == 1) begin
      if (m_cmd == 4'd0) m_stall = 2;
      else if (m_cmd == 4'd3) begin e_ih_reset = 1; m_frame = 0; end
      else if (m_cmd == 4'd2 || (m_cmd == 4'd1 && m_count != 0)) m_stall = 0;
      else begin e_bad = 1; m_frame = 0; end
    end else if (m_stall == 2) begin
      if (mr) begin
        e_ih_ready = 1;
        if (m_cmd == 4'd1 && m_words < int'(m_count)) m_stall = 0;
        else m_frame = 0;
      end
    end else if (acc && s) begin
      if (b == ID) m_start();
      else m_frame = 0;
    end else if (acc) begin
      m_idle = 0;
      m_acc = {m_acc[55:0], b};
      m_pos++;
      if (m_pos == 4) begin
        e_command = {12'h0, m_acc[31:28], 12'h0, m_acc[27:24]};
        e_count   = {4'h0, m_acc[23:0]};
        m_cmd     = m_acc[27:24];
        m_count   = m_acc[23:0];
        m_stall   = 1;
      end else if (m_pos == 8) begin
        e_address = m_acc[31:0];
        if (m_cmd == 4'd2) m_stall = 2;
      end else if (m_pos > 8 && (m_pos - 8) % DB == 0) begin
        e_data = m_acc[DW-1:0];
        m_words++;
        m_stall = 2;
      end
    end else begin
      m_idle++;
      if (m_idle > TMO) begin e_tmo = 1; m_frame = 0; end
    end
  endtask

  int              n_ready, n_bad, n_reset;
  logic [DW-1:0]   seen[$];

  // One cycle: drive at negedge, check ready, update model at posedge, compare at negedge.
  task automatic step(input bit v, input logic [7:0] b, input bit s, input bit mr, output bit acc);
    in_byte_valid = v; in_byte = b; sof = s; master_ready = mr;
    #1;
    chk("in_byte_ready", 64'(in_byte_ready), 64'(m_ready()));
    acc = v && m_ready();
    @(posedge clk);
    m_update(acc, b, s, mr);
    @(negedge clk);
    chk("in_command", 64'(in_command), 64'(e_command));
    chk("in_data_count", 64'(in_data_count), 64'(e_count));
    chk("in_address", 64'(in_address), 64'(e_address));
    chk("in_data", 64'(in_data), 64'(e_data));
    chk("ih_ready", 64'(ih_ready), 64'(e_ih_ready));
    chk("ih_reset", 64'(ih_reset), 64'(e_ih_reset));
    chk("timeout_err", 64'(timeout_err), 64'(e_tmo));
    chk("bad_cmd_err", 64'(bad_cmd_err), 64'(e_bad));
    if (ih_ready === 1'b1) begin n_ready++; seen.push_back(in_data); end
    if (bad_cmd_err === 1'b1) n_bad++;
    if (ih_reset === 1'b1) n_reset++;
  endtask

  task automatic send_seq(input byte_q_t q, input bit first_sof, input bit mr);
    bit acc;
    foreach (q[i]) begin
      int n = 0;
      acc = 0;
      while (!acc && n < 40) begin
        step(1'b1, q[i], (i == 0) && first_sof, mr, acc);
        n++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL send_budget: byte %0h not accepted in 40 cycles, required acceptance", q[i]);
      end
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1, acc);
  endtask

  logic [8:0] stream[$];
  int         stall_left;

  task automatic gen_frame();
    int k;
    logic [3:0]  c, f;
    logic [23:0] cnt;
    logic [8:0]  fr[$];
    k = $urandom_range(0, 9);
    f = 4'($urandom_range(0, 15));
    cnt = 24'($urandom_range(0, 5));
    if (k <= 1) c = 4'd0;
    else if (k <= 4) begin c = 4'd1; cnt = 24'($urandom_range(1, 3)); end
    else if (k <= 6) c = 4'd2;
    else if (k == 7) c = 4'd3;
    else if (k == 8) c = 4'($urandom_range(4, 15));
    else begin c = 4'd1; cnt = 24'd0; end
    fr.push_back({1'b1, ID});
    fr.push_back({1'b0, f, c});
    fr.push_back({1'b0, cnt[23:16]});
    fr.push_back({1'b0, cnt[15:8]});
    fr.push_back({1'b0, cnt[7:0]});
    if (c == 4'd2 || (c == 4'd1 && cnt != 0))
      for (int i = 0; i < 4; i++) fr.push_back({1'b0, 8'($urandom)});
    if (c == 4'd1)
      for (int i = 0; i < int'(cnt) * DB; i++) fr.push_back({1'b0, 8'($urandom)});
    if ($urandom_range(0, 3) == 0) begin
      int keep = $urandom_range(1, fr.size());
      while (fr.size() > keep) void'(fr.pop_back());
    end
    if ($urandom_range(0, 7) == 0) stream.push_back({1'b0, 8'($urandom)});
    if ($urandom_range(0, 9) == 0) stream.push_back({1'b1, 8'h55});
    if ($urandom_range(0, 5) == 0) stall_left = $urandom_range(10, 20);
    foreach (fr[i]) stream.push_back(fr[i]);
  endtask

  initial begin
    bit acc;
    int tmo_at;
    rst = 1'b1; in_byte_valid = 0; in_byte = '0; sof = 0; master_ready = 0;
    #1;
    chk("reset_ready", 64'(in_byte_ready), 64'd0);
    chk("reset_command", 64'(in_command), 64'd0);
    chk("reset_data", 64'(in_data), 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // PING
    n_ready = 0;
    send_seq('{8'hCD, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1);
    idle(4);
    chk("ping_pulses", 64'(n_ready), 64'd1);
    chk("ping_command", 64'(in_command), 64'd0);

    // WRITE of two words
    n_ready = 0; seen.delete();
    send_seq('{8'hCD, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h10, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 1, 1);
    idle(4);
    chk("write_pulses", 64'(n_ready), 64'd2);
    chk("write_address", 64'(in_address), 64'h1000);
    chk("write_count", 64'(in_data_count), 64'd2);
    if (seen.size() == 2) begin
      chk("write_word0", 64'(seen[0]), 64'h11223344);
      chk("write_word1", 64'(seen[1]), 64'h55667788);
    end

    // Timeout inside the header
    send_seq('{8'hCD, 8'h02, 8'h00}, 1, 1);
    tmo_at = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, acc);
      if (timeout_err === 1'b1 && tmo_at == 0) tmo_at = k;
    end
    chk("timeout_cycle", 64'(tmo_at), 64'd17);
    chk("timeout_idle_ready", 64'(in_byte_ready), 64'd1);

    // Backpressure during NOTIFY, next word offered throughout
    n_ready = 0; seen.delete();
    send_seq('{8'hCD, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h20, 8'h00,
               8'h01, 8'h02, 8'h03, 8'h04}, 1, 0);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 8'hA1, 1'b0, 1'b0, acc);
      chk("bp_ready", 64'(in_byte_ready), 64'd0);
    end
    send_seq('{8'hA1, 8'hB2, 8'hC3, 8'hD4}, 0, 1);
    idle(4);
    chk("bp_pulses", 64'(n_ready), 64'd2);
    if (seen.size() == 2) begin
      chk("bp_word0", 64'(seen[0]), 64'h01020304);
      chk("bp_word1", 64'(seen[1]), 64'hA1B2C3D4);
    end

    // Error and reset commands
    n_bad = 0; n_reset = 0;
    send_seq('{8'hCD, 8'h07, 8'h00, 8'h00, 8'h01}, 1, 1);
    idle(3);
    chk("bad_cmd7", 64'(n_bad), 64'd1);
    send_seq('{8'hCD, 8'h01, 8'h00, 8'h00, 8'h00}, 1, 1);
    idle(3);
    chk("bad_write0", 64'(n_bad), 64'd2);
    send_seq('{8'hCD, 8'h03, 8'h00, 8'h00, 8'h00}, 1, 1);
    idle(3);
    chk("ih_reset_pulse", 64'(n_reset), 64'd1);

    // rst mid-DATA
    send_seq('{8'hCD, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04,
               8'h99, 8'h88}, 1, 1);
    in_byte_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 64'(in_byte_ready), 64'd0);
    chk("rst_command", 64'(in_command), 64'd0);
    chk("rst_count", 64'(in_data_count), 64'd0);
    chk("rst_address", 64'(in_address), 64'd0);
    chk("rst_data", 64'(in_data), 64'd0);
    chk("rst_pulses", 64'({ih_ready, ih_reset, timeout_err, bad_cmd_err}), 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    n_ready = 0;
    send_seq('{8'hCD, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1);
    idle(4);
    chk("post_rst_ping", 64'(n_ready), 64'd1);

    // Randomized traffic
    stall_left = 0;
    for (int c = 0; c < 3000; c++) begin
      bit mr, v;
      if (stream.size() == 0) gen_frame();
      mr = ($urandom_range(0, 3) != 0);
      if (stall_left > 0) begin
        stall_left--;
        step(1'b0, 8'h00, 1'b0, mr, acc);
      end else begin
        v = ($urandom_range(0, 4) != 0);
        step(v, stream[0][7:0], stream[0][8], mr, acc);
        if (acc) void'(stream.pop_front());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/host_stream_deframer.md
HOST_STREAM_DEFRAMER -- requirements
Module: host_stream_deframer

Interface
Parameters:
REQ-001 SHALL provide DATA_BYTES, default 4, as the number of bytes per data word (legal range 1..8).
REQ-002 SHALL provide ID_BYTE, default 8'hCD, as the frame start identifier.
REQ-003 SHALL provide TIMEOUT, default 65535, as the maximum number of idle cycles allowed within a frame; 0 disables the timeout.

Ports:
REQ-004 SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_byte  in  8  byte from the host FIFO.
REQ-008 in_byte_valid  in  1  in_byte is valid.
REQ-009 in_byte_ready  out  1  byte accepted when valid and ready are both high.
REQ-010 sof  in  1  marks the first byte of a frame; qualified by in_byte_valid.
REQ-011 master_ready  in  1  master can take a transaction.
REQ-012 ih_ready  out  1  one-cycle pulse: in_* outputs are valid.
REQ-013 ih_reset  out  1  one-cycle pulse: host requested a reset.
REQ-014 in_command  out  32  {12'h0, flags[3:0], 12'h0, cmd[3:0]}.
REQ-015 in_data_count  out  28  {4'h0, count[23:0]}.
REQ-016 in_address  out  32  transaction address.
REQ-017 in_data  out  8*DATA_BYTES  data word.
REQ-018 timeout_err  out  1  one-cycle pulse: frame aborted because the timeout expired.
REQ-019 bad_cmd_err  out  1  one-cycle pulse: unsupported command, or WRITE with count 0.

Function
REQ-020 A byte SHALL be accepted only on a cycle where in_byte_valid and in_byte_ready are both high.
REQ-021 Words SHALL be assembled big-endian (first byte is the MSB). The header and the address are always 4 bytes; data words are DATA_BYTES bytes.
REQ-022 The state machine SHALL have these states: IDLE, HEADER, DECODE, ADDRESS, DATA, NOTIFY.
- IDLE: in_byte_ready=1. Non-frame bytes are discarded. An accepted byte with sof=1 and in_byte==ID_BYTE moves to HEADER.
- HEADER: after the 4th byte, latch in_command and in_data_count, then go to DECODE.
- DECODE (one cycle, in_byte_ready=0), by cmd:
  - PING (0): go to NOTIFY.
  - RESET (3): pulse ih_reset, go to IDLE.
  - READ (2) or WRITE (1): go to ADDRESS.
  - Any other cmd: pulse bad_cmd_err, go to IDLE.
  - WRITE with count 0: pulse bad_cmd_err, go to IDLE.
- ADDRESS: after the 4th byte, latch in_address. READ goes to NOTIFY; WRITE loads remaining=count and goes to DATA.
- DATA: after DATA_BYTES bytes, latch in_data, decrement remaining, go to NOTIFY.
- NOTIFY: in_byte_ready=0. When master_ready=1, pulse ih_ready on the next cycle. Then go to DATA if cmd==WRITE and remaining>0, otherwise go to IDLE.
REQ-023 Latency: the last byte of a word accepted at edge N SHALL update the corresponding in_* register at N. With master_ready held high, ih_ready SHALL be high in cycle N+1.
REQ-024 in_* outputs SHALL hold their values until the next latch or reset.
REQ-025 The timeout counter SHALL reload on every accepted byte and count only in HEADER, ADDRESS and DATA. On expiry: pulse timeout_err, discard the partial word, go to IDLE.
REQ-026 An accepted sof byte in HEADER, ADDRESS or DATA SHALL abort the current frame without an error pulse. It restarts in HEADER if the byte equals ID_BYTE, otherwise goes to IDLE.
REQ-027 If timeout expiry and a sof byte occur in the same cycle, sof SHALL take priority.
REQ-028 remaining SHALL be 24 bits and SHALL never decrement below 0.

Reset
REQ-029 Asserting rst SHALL immediately force: state IDLE; all outputs 0; in_* registers 0; assembler byte count 0; timeout counter = TIMEOUT. This holds even mid-frame.
REQ-030 The first byte accepted after rst deasserts SHALL be evaluated as if in IDLE.

Structure
REQ-031 Package host_if_pkg SHALL hold the command codes (PING, WRITE, READ, RESET), the state enum, and the ID_BYTE default.
REQ-032 Sub-module host_word_assembler (byte shift register, byte counter, word_done strobe; parameter NBYTES) SHALL be instantiated for assembling header, address and data words.

Verification
REQ-033 Bench SHALL cover:
- PING: bytes CD 00 00 00 00 with master_ready=1 -> one ih_ready pulse; in_command=0.
- WRITE: CD 01 00 00 02, address 00001000, data 11223344 and 55667788 -> two ih_ready pulses; in_data values in that order; in_address=32'h1000.
- Timeout: TIMEOUT=16; send CD 02 00; stall 20 cycles -> timeout_err pulse at cycle 17 after the last byte; then IDLE.
- Backpressure: master_ready=0 during NOTIFY for 10 cycles -> in_byte_ready=0 throughout; no bytes lost after release.
- Errors: header cmd=7 -> bad_cmd_err; WRITE count=0 -> bad_cmd_err; RESET header -> ih_reset pulse.
- rst asserted mid-DATA -> all outputs 0 the same cycle; a new PING frame then completes.
